// File: rtl/sha_result_checker_if.sv
// Purpose: bundles the hash input stream, target load and winner-result handshake of sha_result_checker.
// Latency: none (wiring only).
// Backpressure: result side is valid/ready; the hash input side has no backpressure.
// Ports: hash_valid_i/newblock_i/hash_i = hash stream, target_i/target_load_i = difficulty target,
//        result_valid_o/result_ready_i/result_nonce_o/result_word_o = winner queue head, overflow_o = sticky drop flag.
interface sha_result_checker_if;
    logic         hash_valid_i;
    logic         newblock_i;
    logic [255:0] hash_i;
    logic [255:0] target_i;
    logic         target_load_i;
    logic         result_valid_o;
    logic         result_ready_i;
    logic [31:0]  result_nonce_o;
    logic [31:0]  result_word_o;
    logic         overflow_o;

    // master: hash core plus host consumer side
    modport master (
        output hash_valid_i, newblock_i, hash_i, target_i, target_load_i, result_ready_i,
        input  result_valid_o, result_nonce_o, result_word_o, overflow_o
    );

    // slave: the checker itself
    modport slave (
        input  hash_valid_i, newblock_i, hash_i, target_i, target_load_i, result_ready_i,
        output result_valid_o, result_nonce_o, result_word_o, overflow_o
    );
endinterface

// File: rtl/sha_result_checker.sv
// Purpose: tags each double-hash result with its nonce, compares it against the target and queues winners.
// Latency: a winner presented in cycle N shows on result_valid_o in cycle N+2 when the queue is empty.
// Backpressure: none on hash input; a winner arriving at a full queue without a pop is dropped and overflow_o set.
// Ports: clk = clock, rst = synchronous active-low reset, bus = sha_result_checker_if.slave (hash stream,
//        target load, winner valid/ready handshake with nonce and hash word h, sticky overflow).
module sha_result_checker #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    sha_result_checker_if.slave bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   nonce_cnt;
    logic [31:0]   nonce_assign;
    logic [255:0]  target_q;

    logic          s1_vld;
    logic [255:0]  s1_hash;
    logic [31:0]   s1_nonce;

    logic [31:0]   q_nonce [FIFO_DEPTH];
    logic [31:0]   q_word  [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow_q;

    logic          flush;
    logic          winner;
    logic          full;
    logic          q_vld;
    logic          pop;
    logic          push_acc;
    logic          drop;

    always_comb begin
        // A new block restarts the nonce sequence at 0.
        nonce_assign = bus.newblock_i ? 32'd0 : nonce_cnt;
        flush        = bus.hash_valid_i & bus.newblock_i;
        winner       = s1_vld & (s1_hash <= target_q);
        full         = (count == CW'(FIFO_DEPTH));
        // Gating with rst keeps the head invisible (and unpoppable) during a reset cycle.
        q_vld        = (count != '0) & rst;
        pop          = q_vld & bus.result_ready_i;
        // Old-block winners due in the flush cycle are discarded silently.
        push_acc     = winner & ~flush & (~full | pop);
        drop         = winner & ~flush & full & ~pop;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            nonce_cnt  <= '0;
            target_q   <= '1;
            s1_vld     <= 1'b0;
            s1_hash    <= '0;
            s1_nonce   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Takes effect at the end of this cycle, so this cycle's hash sees it one cycle later.
            if (bus.target_load_i) begin
                target_q <= bus.target_i;
            end
            if (bus.hash_valid_i) begin
                nonce_cnt <= nonce_assign + 32'd1;
                s1_hash   <= bus.hash_i;
                s1_nonce  <= nonce_assign;
            end
            s1_vld <= bus.hash_valid_i;

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_acc) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push_acc && !pop) begin
                    count <= count + CW'(1);
                end else if (!push_acc && pop) begin
                    count <= count - CW'(1);
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push_acc && rst) begin
            q_nonce[wr_ptr] <= s1_nonce;
            q_word[wr_ptr]  <= s1_hash[31:0];
        end
    end

    assign bus.result_valid_o = q_vld;
    assign bus.result_nonce_o = q_vld ? q_nonce[rd_ptr] : 32'd0;
    assign bus.result_word_o  = q_vld ? q_word[rd_ptr]  : 32'd0;
    assign bus.overflow_o     = overflow_q;

endmodule
